apb_master: RTL

//  APB initiator (bridge) that drives the peripheral bus shared by the GPIO and UART

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_timeout_cnt.sv | 27 ++
 rtl/apb_master.sv | 138 +++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB bus definitions: bridge FSM states, slave slots, register offsets.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Slave slots decoded from the upper address bits
  localparam int unsigned GPIO_IDX = 0;
  localparam int unsigned UART_IDX = 1;

  // Register offsets shared by the GPIO and UART responders
  localparam int unsigned REG_CTL  = 1;
  localparam int unsigned REG_DIR  = 2;
  localparam int unsigned REG_PORT = 3;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; expired is high during the TIMEOUT-th waiting cycle.
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt;

  // Count waiting cycles; hold once the limit is reached
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// APB bridge: one host request at a time, slave decode, SETUP/ACCESS with timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SLV_W   = 2,
  parameter int unsigned NSLV    = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [NSLV-1:0]        psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [ADDR_W-1:0]      paddr,
  output logic [DATA_W-1:0]      pwdata,
  input  logic [NSLV*DATA_W-1:0] prdata,
  input  logic [NSLV-1:0]        pready,
  input  logic [NSLV-1:0]        pslverr
);

  apb_state_e        state;
  logic [SLV_W-1:0]  req_idx;
  logic              req_mapped;
  logic [NSLV-1:0]   req_sel;
  logic              sel_ready;
  logic              sel_err;
  logic [DATA_W-1:0] sel_rdata;
  logic              tmo_expired;

  assign req_idx   = req_addr[ADDR_W-1 -: SLV_W];
  assign req_ready = (state == IDLE) && !rst;

  // Decode the requested slave index into a one-hot select
  always_comb begin
    req_mapped = 1'b0;
    req_sel    = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (req_idx == SLV_W'(i)) begin
        req_mapped = 1'b1;
        req_sel[i] = 1'b1;
      end
    end
  end

  // psel is one-hot while a transfer runs, so masking picks the selected slave only
  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (psel[i]) begin
        sel_rdata = sel_rdata | prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_ready = |(pready & psel);
  assign sel_err   = |(pslverr & psel);

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == SETUP),
    .en      ((state == ACCESS) && !sel_ready),
    .expired (tmo_expired)
  );

  // Transfer FSM with registered bus and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            pwrite <= req_write;
            paddr  <= req_addr;
            pwdata <= req_wdata;
            if (req_mapped) begin
              psel  <= req_sel;
              state <= SETUP;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready) begin
            rsp_valid <= 1'b1;
            rsp_err   <= sel_err;
            rsp_rdata <= pwrite ? '0 : sel_rdata;
            psel      <= '0;
            penable   <= 1'b0;
            state     <= IDLE;
          end else if (tmo_expired) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          psel    <= '0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
